// File: rtl/reimu_shot.sv
// reimu_shot: four-slot player shot pool with spawn cooldown.
// Shots spawn at the player position plus an x offset and then travel upward.
// A shot is retired when it leaves the top of the screen or is hit.
module reimu_shot #(
  parameter int unsigned SHOT_SPEED = 4,
  parameter int unsigned COOLDOWN   = 6,
  parameter int unsigned SPAWN_DX   = 16
) (
  input  logic        clk22,
  input  logic        gameover,
  input  logic        fire,
  input  logic [9:0]  reimux,
  input  logic [9:0]  reimuy,
  input  logic [3:0]  hit,
  output logic [3:0]  shot_valid,
  output logic [39:0] shotx,
  output logic [39:0] shoty,
  output logic [2:0]  shot_count
);

  localparam logic [9:0] SPEED_W = 10'(SHOT_SPEED);
  localparam logic [9:0] DX_W    = 10'(SPAWN_DX);
  localparam logic [3:0] COOL_W  = 4'(COOLDOWN);

  typedef enum logic {READY, COOL} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [3:0]  valid_q, valid_d;
  logic [9:0]  x_q [4];
  logic [9:0]  x_d [4];
  logic [9:0]  y_q [4];
  logic [9:0]  y_d [4];
  logic [2:0]  count_q, count_d;
  logic        spawn_en;
  logic [1:0]  spawn_idx;

  // Spawn decision: free slots are judged on start-of-tick valid, so a slot
  // freed this tick is not reused until the next one.
  always_comb begin
    spawn_en  = (state_q == READY) && fire && (valid_q != '1);
    spawn_idx = '0;
    for (int unsigned k = 4; k > 0; k--) begin
      if (!valid_q[k-1]) spawn_idx = 2'(k - 1);
    end
  end

  // Per-slot next state: hit beats movement, spawn only into a free slot.
  always_comb begin
    count_d = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      valid_d[k] = valid_q[k];
      x_d[k]     = x_q[k];
      y_d[k]     = y_q[k];
      if (valid_q[k]) begin
        if (hit[k]) begin
          valid_d[k] = 1'b0;
        end else if (y_q[k] >= SPEED_W) begin
          y_d[k] = y_q[k] - SPEED_W;
        end else begin
          valid_d[k] = 1'b0;
        end
      end else if (spawn_en && (spawn_idx == 2'(k))) begin
        valid_d[k] = 1'b1;
        x_d[k]     = reimux + DX_W;
        y_d[k]     = reimuy;
      end
      count_d = count_d + 3'(valid_d[k]);
    end
  end

  // Slot registers, live count and the READY/COOL cooldown FSM.
  always_ff @(posedge clk22) begin
    if (gameover) begin
      state_q <= READY;
      cnt_q   <= '0;
      valid_q <= '0;
      count_q <= '0;
      for (int unsigned k = 0; k < 4; k++) begin
        x_q[k] <= '0;
        y_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
      for (int unsigned k = 0; k < 4; k++) begin
        x_q[k] <= x_d[k];
        y_q[k] <= y_d[k];
      end
      case (state_q)
        READY: begin
          if (spawn_en) begin
            state_q <= COOL;
            cnt_q   <= COOL_W;
          end
        end
        COOL: begin
          if (cnt_q <= 4'd1) begin
            state_q <= READY;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
          state_q <= READY;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Pack slot coordinates onto the flat output buses.
  always_comb begin
    shotx = '0;
    shoty = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      shotx[10*k +: 10] = x_q[k];
      shoty[10*k +: 10] = y_q[k];
    end
  end

  assign shot_valid = valid_q;
  assign shot_count = count_q;

endmodule

// File: tb/tb_reimu_shot.sv
// tb_reimu_shot: directed vectors for the reimu_shot slot pool (default parameters).
module tb_reimu_shot;

  logic        clk22 = 1'b0;
  logic        gameover;
  logic        fire;
  logic [9:0]  reimux;
  logic [9:0]  reimuy;
  logic [3:0]  hit;
  logic [3:0]  shot_valid;
  logic [39:0] shotx;
  logic [39:0] shoty;
  logic [2:0]  shot_count;

  int n_tests = 0;
  int n_fail  = 0;

  reimu_shot #(.SHOT_SPEED(4), .COOLDOWN(6), .SPAWN_DX(16)) dut (
    .clk22      (clk22),
    .gameover   (gameover),
    .fire       (fire),
    .reimux     (reimux),
    .reimuy     (reimuy),
    .hit        (hit),
    .shot_valid (shot_valid),
    .shotx      (shotx),
    .shoty      (shoty),
    .shot_count (shot_count)
  );

  always #5 clk22 = ~clk22;

  // Advance one game tick and settle just after the edge.
  task automatic tick();
    @(posedge clk22);
    #1;
  endtask

  task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    gameover = 1'b1;
    fire     = 1'b0;
    hit      = '0;
    tick();
    gameover = 1'b0;
  endtask

  initial begin
    gameover = 1'b1;
    fire     = 1'b0;
    reimux   = '0;
    reimuy   = '0;
    hit      = '0;

    // Reset state
    tick();
    chk("rst_valid", 40'(shot_valid), 40'd0);
    chk("rst_x",     shotx,           40'd0);
    chk("rst_y",     shoty,           40'd0);
    chk("rst_count", 40'(shot_count), 40'd0);
    gameover = 1'b0;

    // Single fire pulse
    reimux = 10'd100; reimuy = 10'd400; fire = 1'b1;
    tick();
    fire = 1'b0;
    chk("p_valid", 40'(shot_valid),  40'd1);
    chk("p_x0",    40'(shotx[9:0]),  40'd116);
    chk("p_y0",    40'(shoty[9:0]),  40'd400);
    chk("p_count", 40'(shot_count),  40'd1);
    tick();
    chk("p_y0_1",  40'(shoty[9:0]),  40'd396);
    tick();
    chk("p_y0_2",  40'(shoty[9:0]),  40'd392);
    chk("p_x0_2",  40'(shotx[9:0]),  40'd116);

    // Held fire: spawns at ticks 0,7,14,21; tick 28 dropped
    do_reset();
    reimux = 10'd100; reimuy = 10'd400; fire = 1'b1;
    for (int t = 0; t <= 28; t++) begin
      logic [3:0] ev;
      tick();
      ev[0] = 1'b1;
      ev[1] = (t >= 7);
      ev[2] = (t >= 14);
      ev[3] = (t >= 21);
      chk($sformatf("h_valid_t%0d", t), 40'(shot_valid), 40'(ev));
      chk($sformatf("h_count_t%0d", t), 40'(shot_count), 40'($countones(ev)));
    end
    chk("h_y0_t28", 40'(shoty[9:0]),   40'd288);
    chk("h_y3_t28", 40'(shoty[39:30]), 40'd372);
    hit = 4'b0100;
    tick();
    chk("h_valid_t29", 40'(shot_valid), 40'b1011);
    hit = '0;
    tick();
    chk("h_valid_t30", 40'(shot_valid),  40'b1111);
    chk("h_y2_t30",    40'(shoty[29:20]), 40'd400);
    chk("h_x2_t30",    40'(shotx[29:20]), 40'd116);
    chk("h_count_t30", 40'(shot_count),   40'd4);

    // Retire off top from y=3
    do_reset();
    reimux = 10'd50; reimuy = 10'd11; fire = 1'b1;
    tick();
    fire = 1'b0;
    chk("o_y_spawn", 40'(shoty[9:0]), 40'd11);
    tick();
    tick();
    chk("o_y3",       40'(shoty[9:0]),  40'd3);
    chk("o_valid_y3", 40'(shot_valid),  40'd1);
    tick();
    chk("o_valid_off", 40'(shot_valid), 40'd0);
    chk("o_y_held",    40'(shoty[9:0]), 40'd3);
    chk("o_count_off", 40'(shot_count), 40'd0);

    // Boundary y == SHOT_SPEED moves to 0, then retires with y held at 0
    do_reset();
    reimuy = 10'd8; fire = 1'b1;
    tick();
    fire = 1'b0;
    tick();
    tick();
    chk("b_y0",       40'(shoty[9:0]), 40'd0);
    chk("b_valid_y0", 40'(shot_valid), 40'd1);
    tick();
    chk("b_valid_off", 40'(shot_valid), 40'd0);
    chk("b_y_held",    40'(shoty[9:0]), 40'd0);

    // Hit frees slot0 on the same tick as a spawn; spawn goes to slot2
    do_reset();
    reimux = 10'd200; reimuy = 10'd500; fire = 1'b1;
    for (int t = 0; t < 8; t++) tick();
    fire = 1'b0;
    for (int t = 8; t < 14; t++) tick();
    chk("r_valid_pre", 40'(shot_valid), 40'b0011);
    reimux = 10'd300; fire = 1'b1; hit = 4'b0001;
    tick();
    hit = '0;
    chk("r_valid_t14", 40'(shot_valid),   40'b0110);
    chk("r_x2_t14",    40'(shotx[29:20]), 40'd316);
    chk("r_y2_t14",    40'(shoty[29:20]), 40'd500);
    chk("r_x0_held",   40'(shotx[9:0]),   40'd216);
    chk("r_y0_held",   40'(shoty[9:0]),   40'd448);
    chk("r_y1_t14",    40'(shoty[19:10]), 40'd472);
    chk("r_count_t14", 40'(shot_count),   40'd2);
    for (int t = 15; t <= 20; t++) tick();
    chk("r_valid_t20", 40'(shot_valid), 40'b0110);
    tick();
    chk("r_valid_t21", 40'(shot_valid), 40'b0111);
    chk("r_x0_t21",    40'(shotx[9:0]), 40'd316);
    chk("r_y0_t21",    40'(shoty[9:0]), 40'd500);

    // gameover mid-cooldown with three live shots
    do_reset();
    reimux = 10'd100; reimuy = 10'd400; fire = 1'b1;
    for (int t = 0; t <= 17; t++) tick();
    chk("g_valid_pre", 40'(shot_valid), 40'b0111);
    chk("g_count_pre", 40'(shot_count), 40'd3);
    gameover = 1'b1; hit = 4'b1111;
    tick();
    gameover = 1'b0; hit = '0;
    chk("g_valid", 40'(shot_valid), 40'd0);
    chk("g_x",     shotx,           40'd0);
    chk("g_y",     shoty,           40'd0);
    chk("g_count", 40'(shot_count), 40'd0);
    reimux = 10'd5; reimuy = 10'd600; fire = 1'b1;
    tick();
    chk("g_valid_post", 40'(shot_valid), 40'd1);
    chk("g_x0_post",    40'(shotx[9:0]), 40'd21);
    chk("g_y0_post",    40'(shoty[9:0]), 40'd600);

    // hit on free slots alongside a spawn; x offset wraps at 10 bits
    fire = 1'b0;
    for (int t = 0; t < 6; t++) tick();
    reimux = 10'd1020; reimuy = 10'd700; fire = 1'b1; hit = 4'b1010;
    tick();
    fire = 1'b0; hit = '0;
    chk("f_valid", 40'(shot_valid),   40'b0011);
    chk("f_x1",    40'(shotx[19:10]), 40'd12);
    chk("f_y1",    40'(shoty[19:10]), 40'd700);
    chk("f_y0",    40'(shoty[9:0]),   40'd572);
    chk("f_count", 40'(shot_count),   40'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
